sb_param_shadow: RTL and testbench
==================================

Name: sb_param_shadow

Overview:
- Parametrised successor of the fixed 9-track switch block. Four sides (top, right, bottom, left), CHAN_W tracks per side.
- Every output track is driven by a configurable 5-way selector. Each side also has local grid-pin inputs.
- Configuration shifts serially through a shadow chain. It is applied atomically, on a length-checked commit, to an active config register. A partial or over-long bitstream therefore never corrupts live routing.
- Sits in the routing tile between connection blocks and shares the prog_clk configuration chain.

Parameters:
- CHAN_W, 10, tracks per side; must be >= 2.
- PINS, 4, grid-pin inputs per side; must be >= 1.
- SEL_W, 3, select bits per track; fixed, derived by the package.
- CFG_BITS, 4*CHAN_W*SEL_W, shadow/active config length; derived, not overridable.

Ports:
- prog_clk  input  1  configuration clock; sole clock.
- pReset  input  1  synchronous, active-high reset.
- chan_in  input  4*CHAN_W  incoming tracks; index s*CHAN_W+t (s: 0=top, 1=right, 2=bottom, 3=left).
- pin_in  input  4*PINS  grid-pin inputs; index s*PINS+p.
- chan_out  output  4*CHAN_W  outgoing tracks; same indexing as chan_in.
- ccff_head  input  1  serial config data in.
- cfg_shift  input  1  shift enable for the shadow chain.
- cfg_commit  input  1  one-cycle request to apply shadow to active.
- ccff_tail  output  1  shadow[CFG_BITS-1], registered.
- cfg_count  output  $clog2(CFG_BITS+2)  bits shifted since last reset or successful commit.
- cfg_loaded  output  1  active config holds a committed bitstream.
- cfg_err  output  1  sticky: the last commit was rejected.

Behaviour:
- Reset is synchronous on pReset at a prog_clk edge. It clears shadow, active, cfg_count, cfg_loaded and cfg_err to 0.
- After reset, every chan_out is 0 (code 0 = off). ccff_tail is 0.
- Shift: on a cycle with cfg_shift=1 and cfg_commit=0:
  - shadow <= {shadow[CFG_BITS-2:0], ccff_head}.
  - cfg_count increments and saturates at CFG_BITS+1, which means "over-long".
- Field mapping: track f = s*CHAN_W+t takes its select from bits [SEL_W*f+SEL_W-1 : SEL_W*f]. The first bit shifted in ends up at the MSB after CFG_BITS shifts.
- Commit, cfg_commit=1 and cfg_shift=0:
  - If cfg_count == CFG_BITS: active <= shadow, cfg_loaded <= 1, cfg_err <= 0, cfg_count <= 0. Shadow is retained, so the same bitstream can be re-committed only after reloading it.
  - Otherwise: active unchanged, cfg_err <= 1, cfg_count <= 0, shadow unchanged.
- cfg_commit and cfg_shift in the same cycle: the shift is performed, the commit is rejected (cfg_err <= 1, active unchanged), and cfg_count is set to 1.
- Routing is combinational from chan_in, pin_in and active to chan_out, with zero cycles of latency. A new config takes effect the cycle after the commit edge.
- Select codes for output track (s,t):
  - 0: drive 0.
  - 1: chan_in[((s+2)%4)*CHAN_W+t], the opposite side.
  - 2: chan_in[((s+1)%4)*CHAN_W+t], the clockwise neighbour.
  - 3: chan_in[((s+3)%4)*CHAN_W+t], the anticlockwise neighbour.
  - 4: pin_in[s*PINS + (t % PINS)].
  - 5–7: reserved; drive 0.
- A track never selects its own side's input, so there are no combinational loops within the block.
- Reset asserted mid-load discards the partial shadow. Live routing returns to all-off.
- The active register is never written except by a successful commit or by reset.

Decomposition:
- Package sb_param_pkg holds:
  - side localparams SIDE_TOP/RIGHT/BOTTOM/LEFT;
  - SEL_W;
  - select-code localparams SEL_OFF, SEL_OPP, SEL_CW, SEL_CCW, SEL_PIN;
  - functions opp_side, cw_side, ccw_side.
- One sub-module, sb_track_sel: a single-track 5-way selector with inputs opp, cw, ccw, pin and sel[SEL_W-1:0]. It drives 0 for codes 0 and 5–7.
- The top level generates 4*CHAN_W instances of sb_track_sel, the shadow/active registers and the counter/status logic.

Test Plan:
- Reset: assert pReset for 1 cycle with chan_in all-ones. Expect chan_out=0, cfg_count=0, cfg_loaded=0, cfg_err=0, ccff_tail=0.
- Full load, default CHAN_W=10 (120 bits): set top track 0 = code 1 and all other fields 0, shift 120 bits, commit.
  - Expect cfg_loaded=1 and cfg_count=0.
  - Toggling chan_in[20] (bottom t0) toggles chan_out[0] the cycle after the commit edge; all other outputs stay 0.
- Short load: from the previous state, shift 119 bits, then commit. Expect cfg_err=1, cfg_count=0, and routing unchanged (chan_out[0] still follows chan_in[20]).
- Over-long load: shift 121 bits. Expect cfg_count=121 to hold under further shifts; commit gives cfg_err=1 and active unchanged.
- Pin and reserved codes:
  - Right track 5 = code 4: chan_out[15] follows pin_in[1*4+1]=pin_in[5].
  - Left track 2 = code 6: chan_out[32] is 0 regardless of inputs.
- Simultaneous events:
  - cfg_shift and cfg_commit together with cfg_count=120: expect reject, cfg_err=1, cfg_count=1, active unchanged.
  - pReset in the middle of a 60-bit load: expect all outputs 0 and cfg_count=0 on the next cycle.

Source files
------------

// File: rtl/sb_param_pkg.sv
// Shared constants and side helpers for the
// parametrised switch block with shadow config.
package sb_param_pkg;

  localparam int SIDE_TOP    = 0;
  localparam int SIDE_RIGHT  = 1;
  localparam int SIDE_BOTTOM = 2;
  localparam int SIDE_LEFT   = 3;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_OFF = 3'd0;
  localparam logic [SEL_W-1:0] SEL_OPP = 3'd1;
  localparam logic [SEL_W-1:0] SEL_CW  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_CCW = 3'd3;
  localparam logic [SEL_W-1:0] SEL_PIN = 3'd4;

  function automatic int opp_side(input int s);
    return (s + 2) % 4;
  endfunction

  function automatic int cw_side(input int s);
    return (s + 1) % 4;
  endfunction

  function automatic int ccw_side(input int s);
    return (s + 3) % 4;
  endfunction

endpackage

// File: rtl/sb_track_sel.sv
// Single output-track 5-way selector.
// Reserved codes fall to the off state.
module sb_track_sel
  import sb_param_pkg::*;
(
  input  logic             opp,
  input  logic             cw,
  input  logic             ccw,
  input  logic             pin,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  always_comb begin
    out = 1'b0;
    case (sel)
      SEL_OPP: out = opp;
      SEL_CW:  out = cw;
      SEL_CCW: out = ccw;
      SEL_PIN: out = pin;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/sb_param_shadow.sv
// Switch block with serial shadow config chain and
// length-checked atomic commit to the active config.
module sb_param_shadow
  import sb_param_pkg::*;
#(
  parameter  int CHAN_W   = 10,
  parameter  int PINS     = 4,
  localparam int CFG_BITS = 4 * CHAN_W * SEL_W,
  localparam int CNT_W    = $clog2(CFG_BITS + 2)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic [4*CHAN_W-1:0] chan_in,
  input  logic [4*PINS-1:0]   pin_in,
  output logic [4*CHAN_W-1:0] chan_out,
  input  logic                ccff_head,
  input  logic                cfg_shift,
  input  logic                cfg_commit,
  output logic                ccff_tail,
  output logic [CNT_W-1:0]    cfg_count,
  output logic                cfg_loaded,
  output logic                cfg_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                loaded_q, loaded_d;
  logic                err_q, err_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    if (cfg_shift) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
      if (cfg_commit) begin
        // the colliding shift is the first bit of a new load
        count_d = CNT_W'(1);
        err_d   = 1'b1;
      end else if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (cfg_commit) begin
      count_d = '0;
      if (count_q == CNT_FULL) begin
        active_d = shadow_q;
        loaded_d = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail  = shadow_q[CFG_BITS-1];
  assign cfg_count  = count_q;
  assign cfg_loaded = loaded_q;
  assign cfg_err    = err_q;

  for (genvar s = 0; s < 4; s++) begin : g_side
    for (genvar t = 0; t < CHAN_W; t++) begin : g_trk
      localparam int F = s * CHAN_W + t;
      sb_track_sel u_sel (
        .opp (chan_in[opp_side(s) * CHAN_W + t]),
        .cw  (chan_in[cw_side(s) * CHAN_W + t]),
        .ccw (chan_in[ccw_side(s) * CHAN_W + t]),
        .pin (pin_in[s * PINS + (t % PINS)]),
        .sel (active_q[SEL_W*F +: SEL_W]),
        .out (chan_out[F])
      );
    end
  end

endmodule

// File: tb/tb_sb_param_shadow.sv
// Directed bench for sb_param_shadow at default size.
module tb_sb_param_shadow;

  localparam int CW = 10;
  localparam int NB = 120;

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b0;
  logic [39:0]   chan_in = '0;
  logic [15:0]   pin_in = '0;
  logic [39:0]   chan_out;
  logic          ccff_head = 1'b0;
  logic          cfg_shift = 1'b0;
  logic          cfg_commit = 1'b0;
  logic          ccff_tail;
  logic [6:0]    cfg_count;
  logic          cfg_loaded;
  logic          cfg_err;

  int n_run = 0;
  int n_fail = 0;

  sb_param_shadow #(.CHAN_W(CW), .PINS(4)) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .chan_in    (chan_in),
    .pin_in     (pin_in),
    .chan_out   (chan_out),
    .ccff_head  (ccff_head),
    .cfg_shift  (cfg_shift),
    .cfg_commit (cfg_commit),
    .ccff_tail  (ccff_tail),
    .cfg_count  (cfg_count),
    .cfg_loaded (cfg_loaded),
    .cfg_err    (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bits(input logic [NB-1:0] cfg, input int n);
    logic [127:0] v;
    v = {8'b0, cfg};
    for (int i = 0; i < n; i++) begin
      cfg_shift = 1'b1;
      ccff_head = v[n-1-i];
      tick();
    end
    cfg_shift = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    chan_in = '1;
    pin_in = '1;
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    #1;
    n_run++;
    if (chan_out !== 40'h0) begin
      n_fail++;
      $display("FAIL rst_out got %h want 0", chan_out);
    end
    n_run++;
    if (cfg_count !== 7'd0) begin
      n_fail++;
      $display("FAIL rst_cnt got %0d want 0", cfg_count);
    end
    n_run++;
    if (cfg_loaded !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got %b%b want 00", cfg_loaded, cfg_err);
    end
    n_run++;
    if (ccff_tail !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_tail got %b want 0", ccff_tail);
    end
  endtask

  task automatic test_full_load();
    logic [NB-1:0] cfg;
    cfg = '0;
    cfg[2:0] = 3'd1;
    pin_in = '0;
    shift_bits(cfg, NB);
    n_run++;
    if (cfg_count !== 7'd120) begin
      n_fail++;
      $display("FAIL full_cnt got %0d want 120", cfg_count);
    end
    chan_in = '0;
    commit();
    n_run++;
    if (cfg_loaded !== 1'b1 || cfg_count !== 7'd0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_status got l%b c%0d e%b want l1 c0 e0",
               cfg_loaded, cfg_count, cfg_err);
    end
    chan_in[20] = 1'b1;
    #1;
    n_run++;
    if (chan_out !== 40'h1) begin
      n_fail++;
      $display("FAIL full_route1 got %h want 1", chan_out);
    end
    chan_in = '1;
    chan_in[20] = 1'b0;
    #1;
    n_run++;
    if (chan_out !== 40'h0) begin
      n_fail++;
      $display("FAIL full_route0 got %h want 0", chan_out);
    end
  endtask

  task automatic test_short_load();
    shift_bits('1, NB - 1);
    commit();
    n_run++;
    if (cfg_err !== 1'b1 || cfg_count !== 7'd0 || cfg_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL short_status got e%b c%0d l%b want e1 c0 l1",
               cfg_err, cfg_count, cfg_loaded);
    end
    chan_in = '0;
    chan_in[20] = 1'b1;
    #1;
    n_run++;
    if (chan_out !== 40'h1) begin
      n_fail++;
      $display("FAIL short_route got %h want 1", chan_out);
    end
  endtask

  task automatic test_over_long();
    shift_bits('1, NB + 1);
    n_run++;
    if (cfg_count !== 7'd121) begin
      n_fail++;
      $display("FAIL over_cnt got %0d want 121", cfg_count);
    end
    shift_bits('1, 3);
    n_run++;
    if (cfg_count !== 7'd121) begin
      n_fail++;
      $display("FAIL over_sat got %0d want 121", cfg_count);
    end
    commit();
    n_run++;
    if (cfg_err !== 1'b1 || cfg_count !== 7'd0) begin
      n_fail++;
      $display("FAIL over_commit got e%b c%0d want e1 c0", cfg_err, cfg_count);
    end
    chan_in = '1;
    #1;
    n_run++;
    if (chan_out !== 40'h1) begin
      n_fail++;
      $display("FAIL over_route got %h want 1", chan_out);
    end
  endtask

  task automatic test_pin_reserved();
    logic [NB-1:0] cfg;
    cfg = '0;
    cfg[2:0]   = 3'd1;
    cfg[5:3]   = 3'd2;
    cfg[8:6]   = 3'd3;
    cfg[47:45] = 3'd4;
    cfg[89:87] = 3'd1;
    cfg[98:96] = 3'd6;
    shift_bits(cfg, NB);
    commit();
    n_run++;
    if (cfg_err !== 1'b0 || cfg_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL pin_commit got e%b l%b want e0 l1", cfg_err, cfg_loaded);
    end
    chan_in = '1;
    pin_in = '0;
    #1;
    n_run++;
    if (chan_out !== 40'h0_2000_0007) begin
      n_fail++;
      $display("FAIL pin_allch got %h want 0020000007", chan_out);
    end
    chan_in = '0;
    pin_in = 16'h0020;
    #1;
    n_run++;
    if (chan_out !== 40'h0_0000_8000) begin
      n_fail++;
      $display("FAIL pin_p5 got %h want 0000008000", chan_out);
    end
    pin_in = 16'hffdf;
    #1;
    n_run++;
    if (chan_out !== 40'h0) begin
      n_fail++;
      $display("FAIL pin_not5 got %h want 0", chan_out);
    end
    pin_in = '0;
    chan_in = 40'h0_0000_0800;
    #1;
    n_run++;
    if (chan_out !== 40'h2) begin
      n_fail++;
      $display("FAIL cw_route got %h want 2", chan_out);
    end
    chan_in = 40'h1_0000_0000;
    #1;
    n_run++;
    if (chan_out !== 40'h4) begin
      n_fail++;
      $display("FAIL ccw_route got %h want 4", chan_out);
    end
    chan_in = 40'h0_0000_0200;
    #1;
    n_run++;
    if (chan_out !== 40'h0_2000_0000) begin
      n_fail++;
      $display("FAIL edge_t9 got %h want 0020000000", chan_out);
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] cfg;
    cfg = '0;
    cfg[NB-1] = 1'b1;
    shift_bits(cfg, NB);
    n_run++;
    if (ccff_tail !== 1'b1 || cfg_count !== 7'd120) begin
      n_fail++;
      $display("FAIL sim_pre got t%b c%0d want t1 c120", ccff_tail, cfg_count);
    end
    cfg_shift = 1'b1;
    cfg_commit = 1'b1;
    ccff_head = 1'b0;
    tick();
    cfg_shift = 1'b0;
    cfg_commit = 1'b0;
    n_run++;
    if (cfg_err !== 1'b1 || cfg_count !== 7'd1) begin
      n_fail++;
      $display("FAIL sim_status got e%b c%0d want e1 c1", cfg_err, cfg_count);
    end
    chan_in = '1;
    pin_in = '1;
    #1;
    n_run++;
    if (chan_out !== 40'h0_2000_8007) begin
      n_fail++;
      $display("FAIL sim_route got %h want 0020008007", chan_out);
    end
  endtask

  task automatic test_reset_mid_load();
    shift_bits('1, 60);
    cfg_shift = 1'b1;
    ccff_head = 1'b1;
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    cfg_shift = 1'b0;
    ccff_head = 1'b0;
    chan_in = '1;
    pin_in = '1;
    #1;
    n_run++;
    if (chan_out !== 40'h0 || cfg_count !== 7'd0) begin
      n_fail++;
      $display("FAIL mid_rst got o%h c%0d want o0 c0", chan_out, cfg_count);
    end
    n_run++;
    if (cfg_loaded !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_flags got l%b e%b want l0 e0", cfg_loaded, cfg_err);
    end
    shift_bits('0, NB);
    n_run++;
    if (ccff_tail !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_tail got %b want 0", ccff_tail);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_full_load();
    test_short_load();
    test_over_long();
    test_pin_reserved();
    test_simultaneous();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
